// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge bundle for the shared instruction/data port.
// The controller is the master; the memory side is the slave.
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_we_o;
    logic iord_o;
    logic mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output iord_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  iord_o,
        output mem_ack_i
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32I-subset datapath on a shared memory port.
// Optional MCC_TRAP_EN: illegal encodings enter a sticky TRAP state instead of a NOP.
module multicycle_ctrl (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic                  zero_i,
    input  logic                  blt_i,
    input  logic                  bge_i,
    multicycle_ctrl_if.master     mem,
    output logic                  ir_we_o,
    output logic                  oldpc_we_o,
    output logic                  mdr_we_o,
    output logic                  pc_we_o,
    output logic                  reg_we_o,
    output logic                  pc_src_o,
    output logic [1:0]            alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic [1:0]            alu_op_o,
    output logic [1:0]            wb_sel_o,
    output logic [3:0]            state_o,
    output logic                  trap_o
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_ALU = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_JALR   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

`ifdef MCC_TRAP_EN
    localparam logic [3:0] S_ILLEGAL = S_TRAP;
`else
    localparam logic [3:0] S_ILLEGAL = S_FETCH;
`endif

    logic [3:0] state;
    logic [3:0] state_nx;

    logic       req;
    logic       we;
    logic       iord;
    logic       ir_we;
    logic       oldpc_we;
    logic       mdr_we;
    logic       pc_we;
    logic       reg_we;
    logic       pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] aop;
    logic [1:0] wb;
    logic       trap;

    logic       is_r;
    logic       is_i;
    logic       is_ls;
    logic       is_br;
    logic       is_jal;
    logic       is_jalr;
    logic       br_legal;
    logic       br_cond;
    logic       ack;

    assign ack     = mem.mem_ack_i;
    assign is_r    = (opcode_i == OP_R);
    assign is_i    = (opcode_i == OP_I);
    assign is_ls   = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
    assign is_br   = (opcode_i == OP_BRANCH);
    assign is_jal  = (opcode_i == OP_JAL);
    assign is_jalr = (opcode_i == OP_JALR);

    // Branch condition from funct3; unsupported funct3 values are illegal.
    always_comb begin
        br_legal = 1'b1;
        br_cond  = 1'b0;
        unique case (funct3_i)
            3'b000:  br_cond = zero_i;
            3'b001:  br_cond = !zero_i;
            3'b100:  br_cond = blt_i;
            3'b101:  br_cond = bge_i;
            default: br_legal = 1'b0;
        endcase
    end

    // Moore outputs per state, with ack/branch-condition gating on enables.
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        we       = 1'b0;
        iord     = 1'b0;
        ir_we    = 1'b0;
        oldpc_we = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        pc_src   = 1'b0;
        src_a    = 2'd0;
        src_b    = 2'd0;
        aop      = 2'b00;
        wb       = 2'd0;
        trap     = 1'b0;
        case (state)
            S_FETCH: begin
                req   = 1'b1;
                src_b = 2'd1;
                if (ack) begin
                    ir_we    = 1'b1;
                    oldpc_we = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = 2'd1;
                src_b = 2'd2;
                unique case (1'b1)
                    is_r:    state_nx = S_EXEC_R;
                    is_i:    state_nx = S_EXEC_I;
                    is_ls:   state_nx = S_ADDR;
                    is_br:   state_nx = S_BRANCH;
                    is_jal:  state_nx = S_JAL;
                    is_jalr: state_nx = S_JALR;
                    default: state_nx = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                src_a    = 2'd2;
                aop      = 2'b10;
                state_nx = S_WB_ALU;
            end
            S_EXEC_I: begin
                src_a    = 2'd2;
                src_b    = 2'd2;
                aop      = 2'b10;
                state_nx = S_WB_ALU;
            end
            S_ADDR: begin
                src_a    = 2'd2;
                src_b    = 2'd2;
                state_nx = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                req  = 1'b1;
                iord = 1'b1;
                if (ack) begin
                    mdr_we   = 1'b1;
                    state_nx = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                req  = 1'b1;
                we   = 1'b1;
                iord = 1'b1;
                if (ack) begin
                    state_nx = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_we   = 1'b1;
                state_nx = S_FETCH;
            end
            S_WB_MEM: begin
                reg_we   = 1'b1;
                wb       = 2'd1;
                state_nx = S_FETCH;
            end
            S_BRANCH: begin
                src_a    = 2'd2;
                aop      = 2'b01;
                pc_src   = 1'b1;
                pc_we    = br_legal && br_cond;
                state_nx = br_legal ? S_FETCH : S_ILLEGAL;
            end
            S_JAL: begin
                pc_we    = 1'b1;
                pc_src   = 1'b1;
                reg_we   = 1'b1;
                wb       = 2'd2;
                state_nx = S_FETCH;
            end
            S_JALR: begin
                src_a    = 2'd2;
                src_b    = 2'd2;
                pc_we    = 1'b1;
                reg_we   = 1'b1;
                wb       = 2'd2;
                state_nx = S_FETCH;
            end
`ifdef MCC_TRAP_EN
            S_TRAP: begin
                trap     = 1'b1;
                state_nx = S_TRAP;
            end
`endif
            default: state_nx = S_FETCH;
        endcase
    end

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    assign state_o       = state;
    assign mem.mem_req_o = req      && !rst_i;
    assign mem.mem_we_o  = we       && !rst_i;
    assign mem.iord_o    = iord     && !rst_i;
    assign ir_we_o       = ir_we    && !rst_i;
    assign oldpc_we_o    = oldpc_we && !rst_i;
    assign mdr_we_o      = mdr_we   && !rst_i;
    assign pc_we_o       = pc_we    && !rst_i;
    assign reg_we_o      = reg_we   && !rst_i;
    assign pc_src_o      = pc_src   && !rst_i;
    assign alu_src_a_o   = rst_i ? 2'd0 : src_a;
    assign alu_src_b_o   = rst_i ? 2'd0 : src_b;
    assign alu_op_o      = rst_i ? 2'd0 : aop;
    assign wb_sel_o      = rst_i ? 2'd0 : wb;
`ifdef MCC_TRAP_EN
    assign trap_o        = trap && !rst_i;
`else
    assign trap_o        = 1'b0;
    logic unused_trap;
    assign unused_trap   = trap;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are
// queued as stimulus is driven and compared on the falling clock edge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       iord;
        logic       ir;
        logic       opc;
        logic       mdr;
        logic       pcw;
        logic       regw;
        logic       pcs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] wb;
        logic       trap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       blt;
    logic       bge;
    logic       ir_we;
    logic       oldpc_we;
    logic       mdr_we;
    logic       pc_we;
    logic       reg_we;
    logic       pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] aop;
    logic [1:0] wb_sel;
    logic [3:0] state;
    logic       trap;

    int checks = 0;
    int errors = 0;

    exp_t  sb[$];
    string tags[$];
    exp_t  obs;

    multicycle_ctrl_if mem ();

    multicycle_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .zero_i      (zero),
        .blt_i       (blt),
        .bge_i       (bge),
        .mem         (mem.master),
        .ir_we_o     (ir_we),
        .oldpc_we_o  (oldpc_we),
        .mdr_we_o    (mdr_we),
        .pc_we_o     (pc_we),
        .reg_we_o    (reg_we),
        .pc_src_o    (pc_src),
        .alu_src_a_o (src_a),
        .alu_src_b_o (src_b),
        .alu_op_o    (aop),
        .wb_sel_o    (wb_sel),
        .state_o     (state),
        .trap_o      (trap)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs = {state, mem.mem_req_o, mem.mem_we_o, mem.iord_o, ir_we,
               oldpc_we, mdr_we, pc_we, reg_we, pc_src, src_a, src_b,
               aop, wb_sel, trap};
    end

    // Expected control word for a state, straight from the state table.
    function automatic exp_t spec_out(input logic [3:0] s, input logic ack,
                                      input logic cond);
        exp_t e;
        e = '0;
        e.st = s;
        case (s)
            4'd0: begin
                e.req = 1'b1; e.b = 2'd1;
                e.ir = ack; e.opc = ack; e.pcw = ack;
            end
            4'd1: begin e.a = 2'd1; e.b = 2'd2; end
            4'd2: begin e.a = 2'd2; e.op = 2'b10; end
            4'd3: begin e.a = 2'd2; e.b = 2'd2; e.op = 2'b10; end
            4'd4: begin e.a = 2'd2; e.b = 2'd2; end
            4'd5: begin e.req = 1'b1; e.iord = 1'b1; e.mdr = ack; end
            4'd6: begin e.req = 1'b1; e.we = 1'b1; e.iord = 1'b1; end
            4'd7: e.regw = 1'b1;
            4'd8: begin e.regw = 1'b1; e.wb = 2'd1; end
            4'd9: begin e.a = 2'd2; e.op = 2'b01; e.pcs = 1'b1; e.pcw = cond; end
            4'd10: begin e.pcw = 1'b1; e.pcs = 1'b1; e.regw = 1'b1; e.wb = 2'd2; end
            4'd11: begin
                e.a = 2'd2; e.b = 2'd2; e.pcw = 1'b1;
                e.regw = 1'b1; e.wb = 2'd2;
            end
            4'd15: e.trap = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Everything zero while reset is held; state is whatever it was.
    function automatic exp_t rst_out(input logic [3:0] s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    // Compare each queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            string t;
            e = sb.pop_front();
            t = tags.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h (state %0d vs %0d)",
                         t, obs, e, obs.st, e.st);
            end
        end
    end

    task automatic step(input exp_t e, input string tag);
        sb.push_back(e);
        tags.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f,
                          input logic ack);
        opcode = o;
        funct3 = f;
        mem.mem_ack_i = ack;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(7'd0, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({mem.mem_req_o, mem.mem_we_o, mem.iord_o, ir_we, oldpc_we,
                 mdr_we, pc_we, reg_we, pc_src, src_a, src_b, aop, wb_sel,
                 trap} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h required 0",
                         obs[20:0]);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        set_in(7'd0, 3'd0, 1'b0);
        step(spec_out(4'd0, 1'b0, 1'b0), "reset_first_fetch");
    endtask

    task automatic test_add;
        set_in(7'b0110011, 3'd0, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "add_fetch");
        set_in(7'b0110011, 3'd0, 1'b0);
        step(spec_out(4'd1, 1'b0, 1'b0), "add_decode");
        step(spec_out(4'd2, 1'b0, 1'b0), "add_exec_r");
        step(spec_out(4'd7, 1'b0, 1'b0), "add_wb_alu");
    endtask

    task automatic test_addi;
        set_in(7'b0010011, 3'd0, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "addi_fetch");
        step(spec_out(4'd1, 1'b0, 1'b0), "addi_decode_ack_ignored");
        step(spec_out(4'd3, 1'b0, 1'b0), "addi_exec_i");
        step(spec_out(4'd7, 1'b0, 1'b0), "addi_wb_alu");
    endtask

    task automatic test_load;
        set_in(7'b0000011, 3'b010, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "lw_fetch");
        set_in(7'b0000011, 3'b010, 1'b0);
        step(spec_out(4'd1, 1'b0, 1'b0), "lw_decode");
        step(spec_out(4'd4, 1'b0, 1'b0), "lw_addr");
        step(spec_out(4'd5, 1'b0, 1'b0), "lw_mem_wait1");
        step(spec_out(4'd5, 1'b0, 1'b0), "lw_mem_wait2");
        mem.mem_ack_i = 1'b1;
        step(spec_out(4'd5, 1'b1, 1'b0), "lw_mem_ack");
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd8, 1'b0, 1'b0), "lw_wb_mem");
    endtask

    task automatic test_store;
        set_in(7'b0100011, 3'b010, 1'b0);
        step(spec_out(4'd0, 1'b0, 1'b0), "sw_fetch_wait");
        mem.mem_ack_i = 1'b1;
        step(spec_out(4'd0, 1'b1, 1'b0), "sw_fetch_ack");
        step(spec_out(4'd1, 1'b1, 1'b0), "sw_decode");
        step(spec_out(4'd4, 1'b1, 1'b0), "sw_addr");
        step(spec_out(4'd6, 1'b1, 1'b0), "sw_mem_wr");
        mem.mem_ack_i = 1'b0;
    endtask

    task automatic run_branch(input logic [2:0] f, input logic z,
                              input logic lt, input logic ge,
                              input logic taken, input string tag);
        zero = z;
        blt  = lt;
        bge  = ge;
        set_in(7'b1100011, f, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), {tag, "_fetch"});
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd1, 1'b0, 1'b0), {tag, "_decode"});
        step(spec_out(4'd9, 1'b0, taken), {tag, "_branch"});
        zero = 1'b0;
        blt  = 1'b0;
        bge  = 1'b0;
    endtask

    task automatic test_branch;
        run_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");
        run_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "bne_not_taken");
        run_branch(3'b101, 1'b0, 1'b0, 1'b1, 1'b1, "bge_taken");
        run_branch(3'b100, 1'b0, 1'b0, 1'b1, 1'b0, "blt_not_taken");
        run_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, "blt_taken");
    endtask

    task automatic test_jumps;
        set_in(7'b1101111, 3'd0, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "jal_fetch");
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd1, 1'b0, 1'b0), "jal_decode");
        step(spec_out(4'd10, 1'b0, 1'b0), "jal_jal");
        set_in(7'b1100111, 3'd0, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "jalr_fetch");
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd1, 1'b0, 1'b0), "jalr_decode");
        step(spec_out(4'd11, 1'b0, 1'b0), "jalr_jalr");
    endtask

    task automatic do_reset(input logic [3:0] s, input string tag);
        rst = 1'b1;
        mem.mem_ack_i = 1'b0;
        step(rst_out(s), tag);
        rst = 1'b0;
    endtask

    task automatic test_illegal;
        set_in(7'b0000000, 3'd0, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "illop_fetch");
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd1, 1'b0, 1'b0), "illop_decode");
`ifdef MCC_TRAP_EN
        step(spec_out(4'd15, 1'b0, 1'b0), "illop_trap1");
        mem.mem_ack_i = 1'b1;
        step(spec_out(4'd15, 1'b0, 1'b0), "illop_trap2");
        step(spec_out(4'd15, 1'b0, 1'b0), "illop_trap3");
        do_reset(4'd15, "illop_trap_reset");
`endif
        zero = 1'b1;
        set_in(7'b1100011, 3'b010, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "illbr_fetch");
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd1, 1'b0, 1'b0), "illbr_decode");
        step(spec_out(4'd9, 1'b0, 1'b0), "illbr_branch");
        zero = 1'b0;
`ifdef MCC_TRAP_EN
        step(spec_out(4'd15, 1'b0, 1'b0), "illbr_trap");
        do_reset(4'd15, "illbr_trap_reset");
`endif
    endtask

    task automatic test_reset_abort;
        set_in(7'b0100011, 3'b010, 1'b1);
        step(spec_out(4'd0, 1'b1, 1'b0), "abort_fetch");
        mem.mem_ack_i = 1'b0;
        step(spec_out(4'd1, 1'b0, 1'b0), "abort_decode");
        step(spec_out(4'd4, 1'b0, 1'b0), "abort_addr");
        step(spec_out(4'd6, 1'b0, 1'b0), "abort_wr_wait1");
        step(spec_out(4'd6, 1'b0, 1'b0), "abort_wr_wait2");
        do_reset(4'd6, "abort_reset_drops_req");
        step(spec_out(4'd0, 1'b0, 1'b0), "abort_back_to_fetch");
    endtask

    initial begin
        rst = 1'b1;
        opcode = '0;
        funct3 = '0;
        zero = 1'b0;
        blt = 1'b0;
        bge = 1'b0;
        mem.mem_ack_i = 1'b0;
        test_reset();
        test_add();
        test_addi();
        test_load();
        test_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_abort();
        set_in(7'd0, 3'd0, 1'b0);
        step(spec_out(4'd0, 1'b0, 1'b0), "final_fetch");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style main control FSM that sequences a shared-memory RV32I-subset datapath (PC, IR, old-PC, MDR, ALUOut registers, register file, ALU) over several cycles per instruction. It replaces the single-cycle combinational decoder when instruction and data memory are merged behind one request/acknowledge port. It drives every write enable and mux select in the datapath. It consumes opcode/funct3 from the IR and the ALU condition flags.

## Interface
No parameters.
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- opcode_i  in  7  IR[6:0]
- funct3_i  in  3  IR[14:12]
- zero_i / blt_i / bge_i  in  1 each  ALU flags for current ALU operands
- mem_ack_i  in  1  memory completed request this cycle
- mem_req_o  out  1  memory access request, held until ack
- mem_we_o  out  1  request is a write (valid with mem_req_o)
- iord_o  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_we_o / oldpc_we_o / mdr_we_o / pc_we_o / reg_we_o  out  1 each  register write enables
- pc_src_o  out  1  PC input: 0 = ALU result, 1 = ALUOut
- alu_src_a_o  out  2  0 = PC, 1 = oldPC, 2 = rs1
- alu_src_b_o  out  2  0 = rs2, 1 = constant 4, 2 = immediate
- alu_op_o  out  2  00 add, 01 subtract/compare, 10 decode funct fields
- wb_sel_o  out  2  register write data: 0 = ALUOut, 1 = MDR, 2 = PC
- state_o  out  4  current state encoding (debug)
- trap_o  out  1  illegal instruction trap (see Configuration)

## Operation
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JAL 10, JALR 11, TRAP 15. Codes 12–14 are unused and return to FETCH.
- Per-state outputs; any output not listed is 0:
  - FETCH: mem_req=1, iord=0, a=0, b=1, op=00. On mem_ack: ir_we, oldpc_we, pc_we (pc_src=0), then → DECODE.
  - DECODE: a=1, b=2, op=00 (ALUOut ← oldPC+imm). Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 / 0100011 → ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - else illegal
  - EXEC_R: a=2, b=0, op=10 → WB_ALU. EXEC_I: a=2, b=2, op=10 → WB_ALU.
  - ADDR: a=2, b=2, op=00. Goes → MEM_RD if opcode 0000011, else → MEM_WR.
  - MEM_RD: mem_req, iord=1. On ack: mdr_we, → WB_MEM.
  - MEM_WR: mem_req, mem_we, iord=1. On ack → FETCH.
  - WB_ALU: reg_we, wb=0 → FETCH. WB_MEM: reg_we, wb=1 → FETCH.
  - BRANCH: a=2, b=0, op=01. pc_we=cond, pc_src=1, → FETCH. cond by funct3:
    - 000: zero
    - 001: !zero
    - 100: blt
    - 101: bge
    - other funct3 is illegal.
  - JAL: pc_we, pc_src=1, reg_we, wb=2 → FETCH.
  - JALR: a=2, b=2, op=00, pc_we, pc_src=0, reg_we, wb=2 → FETCH.
    - The register write captures the old PC (oldPC+4) on the same edge the PC updates, so rd==rs1 is safe.
- opcode_i and funct3_i are sampled in every post-FETCH state. The IR is stable because ir_we asserts only in FETCH.

## Timing
- Reset: on a rising edge with rst_i=1, state ← FETCH. Reset has priority over every transition, including mid memory wait.
  - While rst_i=1, all enables, mem_req_o and trap_o are forced to 0. Selects are 0.
  - The first fetch request is issued the cycle after rst_i falls.
- Outputs are combinational from state. mem_ack_i gates ir/oldpc/pc/mdr enables and branch cond gates pc_we (Mealy on same cycle).
- Handshake rules:
  - mem_req_o, mem_we_o and iord_o stay stable until the cycle mem_ack_i=1.
  - An ack in the same cycle as the first request is legal.
  - mem_ack_i outside FETCH/MEM_RD/MEM_WR is ignored.
  - There is no timeout; the FSM waits indefinitely.
- Latency with zero-wait memory, in cycles:
  - R/I: 4
  - load: 5
  - store: 4
  - branch (taken or not): 3
  - JAL/JALR: 3
  - Each wait cycle adds 1 to FETCH or MEM_*.

## Configuration
- MCC_TRAP_EN defined:
  - An illegal opcode (DECODE) or illegal branch funct3 (BRANCH, with pc_we=0) → TRAP.
  - TRAP holds all enables at 0, trap_o=1, and is exited only by rst_i.
- MCC_TRAP_EN undefined:
  - Illegal encodings → FETCH with no state written (NOP).
  - TRAP is unreachable and trap_o is tied to 0.

## Test plan
- Reset: rst_i=1 for 2 cycles, then release → state_o=0, mem_req_o=1 and iord_o=0 the following cycle. All enables are 0 during reset.
- add x3,x1,x2 with ack in the same cycle → states 0,1,2,7. reg_we=1 with wb_sel=0 in cycle 4, then state_o=0.
- lw with 2 wait cycles on the data access → MEM_RD is held for 3 cycles with iord=1 and mem_we=0. mdr_we pulses only on the ack cycle. WB_MEM follows; 7 cycles total.
- Branches:
  - beq with zero_i=1 → pc_we=1, pc_src=1 in BRANCH.
  - bne with zero_i=1 → pc_we=0.
  - bge with bge_i=1 → taken.
  - Each completes in 3 cycles.
- jalr x1,0(x1) → JALR asserts pc_we, reg_we, wb_sel=2, pc_src=0 in the same cycle.
- Illegal and reset-abort cases:
  - opcode 0000000 with MCC_TRAP_EN → state 15, trap_o=1, held until reset. Without the macro → FETCH next cycle.
  - rst_i asserted mid MEM_WR wait → FETCH, and mem_req_o drops.
